cfd_config_sequencer: RTL

Parametrised write sequencer for the CFD chip's parallel configuration port. Accepts per-channel or broadcast configuration commands over a valid/ready handshake and serialises each into a header byte (mode, address) and a data byte on DATA, each qualified by a programmable-width STB pulse. It also generates the chip's RST_L pulse and replaces fixed-width, hand-timed DATA/STB stimulus with a channel-count-generic, cycle-exact engine.

---
 rtl/cfd_config_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cfd_config_sequencer.sv
// Write sequencer for the CFD parallel configuration port: serialises header/data byte pairs
// with programmable setup/strobe/hold timing and generates the chip RST_L pulse.
module cfd_config_sequencer #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned MODE_BITS = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CHANNELS  = 16,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned STB_CYC   = 4,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned RSTL_CYC  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [ADDR_BITS-1:0] CMD_ADDR,
    input  logic [MODE_BITS-1:0] CMD_MODE,
    input  logic [DATA_BITS-1:0] CMD_DATA,
    input  logic                 CMD_BCAST,
    input  logic                 CHIP_RST_REQ,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 STB,
    output logic                 RST_L,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [15:0]          WR_COUNT
);

    typedef enum logic [3:0] {
        ChipRst, Idle, HSetup, HStb, HHold, DSetup, DStb, DHold, Fin
    } state_e;

    localparam logic [15:0]          SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0]          STB_LAST   = 16'(STB_CYC - 1);
    localparam logic [15:0]          HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0]          RSTL_LAST  = 16'(RSTL_CYC - 1);
    localparam logic [ADDR_BITS-1:0] LAST_CH    = ADDR_BITS'(CHANNELS - 1);

    state_e                 state;
    logic [15:0]            cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [MODE_BITS-1:0]   mode_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   bcast_q;
    logic [ADDR_BITS-1:0]   addr_inc;
    logic                   addr_bad;

    assign addr_inc = addr_q + ADDR_BITS'(1);
    assign addr_bad = 32'(CMD_ADDR) >= CHANNELS;

    // Outputs are assigned on state transitions so every one of them is a flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ChipRst;
            cnt       <= '0;
            DATA      <= '0;
            STB       <= 1'b0;
            RST_L     <= 1'b0;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            WR_COUNT  <= '0;
            addr_q    <= '0;
            mode_q    <= '0;
            data_q    <= '0;
            bcast_q   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                ChipRst: begin
                    if (cnt == RSTL_LAST) begin
                        state     <= Idle;
                        cnt       <= '0;
                        RST_L     <= 1'b1;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                Idle: begin
                    if (CHIP_RST_REQ) begin
                        state     <= ChipRst;
                        cnt       <= '0;
                        RST_L     <= 1'b0;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                    end else if (CMD_VALID) begin
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        cnt       <= '0;
                        mode_q    <= CMD_MODE;
                        data_q    <= CMD_DATA;
                        bcast_q   <= CMD_BCAST;
                        if (CMD_BCAST) begin
                            addr_q <= '0;
                            state  <= HSetup;
                            DATA   <= {CMD_MODE, {ADDR_BITS{1'b0}}};
                        end else if (addr_bad) begin
                            // Rejected: skip the bus entirely and report straight away.
                            addr_q <= CMD_ADDR;
                            state  <= Fin;
                            DONE   <= 1'b1;
                            ERR    <= 1'b1;
                        end else begin
                            addr_q <= CMD_ADDR;
                            state  <= HSetup;
                            DATA   <= {CMD_MODE, CMD_ADDR};
                        end
                    end
                end
                HSetup, DSetup: begin
                    if (cnt == SETUP_LAST) begin
                        state <= (state == HSetup) ? HStb : DStb;
                        cnt   <= '0;
                        STB   <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HStb, DStb: begin
                    if (cnt == STB_LAST) begin
                        state <= (state == HStb) ? HHold : DHold;
                        cnt   <= '0;
                        STB   <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HHold: begin
                    if (cnt == HOLD_LAST) begin
                        state <= DSetup;
                        cnt   <= '0;
                        DATA  <= data_q;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DHold: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        WR_COUNT <= WR_COUNT + 16'd1;
                        if (bcast_q && addr_q != LAST_CH) begin
                            addr_q <= addr_inc;
                            state  <= HSetup;
                            DATA   <= {mode_q, addr_inc};
                        end else begin
                            state <= Fin;
                            DATA  <= '0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                Fin: begin
                    state     <= Idle;
                    CMD_READY <= 1'b1;
                    BUSY      <= 1'b0;
                end
                default: begin
                    state <= ChipRst;
                    cnt   <= '0;
                    RST_L <= 1'b0;
                    BUSY  <= 1'b1;
                end
            endcase
        end
    end

endmodule
